// File: rtl/soml_pkg.sv
// Shared definitions for the SOML H*X dot-product sequencing slice:
// matrix indices, geometry, Q7.8 widths and result-address packing.
package soml_pkg;

  localparam int NUM_MAT = 4;
  localparam int NUM_ROW = 4;
  localparam int NUM_COL = 2;
  localparam int MAT_W   = 2;
  localparam int ROW_W   = 2;
  localparam int COL_W   = 1;
  localparam int ADDR_W  = MAT_W + COL_W + ROW_W;
  localparam int NUM_ENT = NUM_MAT * NUM_COL * NUM_ROW;

  localparam int W    = 16;
  localparam int FRAC = 8;

  localparam logic [MAT_W-1:0] MAT_A1 = 2'd0;
  localparam logic [MAT_W-1:0] MAT_A2 = 2'd1;
  localparam logic [MAT_W-1:0] MAT_B1 = 2'd2;
  localparam logic [MAT_W-1:0] MAT_B2 = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  function automatic logic [ADDR_W-1:0] res_addr(
    input logic [MAT_W-1:0] mat,
    input logic [COL_W-1:0] col,
    input logic [ROW_W-1:0] row
  );
    return {mat, col, row};
  endfunction

  // Lowest enabled matrix index >= from; MSB of the result flags "found".
  function automatic logic [MAT_W:0] next_mat(
    input logic [NUM_MAT-1:0] mask,
    input logic [MAT_W:0]     from
  );
    logic [MAT_W:0] r;
    r = '0;
    for (int i = NUM_MAT - 1; i >= 0; i--) begin
      if (mask[i] && (i >= int'(from))) r = {1'b1, MAT_W'(i)};
    end
    return r;
  endfunction

endpackage

// File: rtl/soml_tag_delay.sv
// Shift register carrying {valid, tag} alongside the cmult pipeline.
// Only the valid bits are cleared; tags are don't-care when invalid.
module soml_tag_delay #(
  parameter int LAT   = 2,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  output logic [TAG_W-1:0] out_tag
);

  logic [LAT-1:0]   vld_p;
  logic [TAG_W-1:0] tag_p [LAT];

  always_ff @(posedge clk) begin
    if (clr) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= in_valid;
      for (int i = 1; i < LAT; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    tag_p[0] <= in_tag;
    for (int i = 1; i < LAT; i++) tag_p[i] <= tag_p[i-1];
  end

  assign out_valid = vld_p[LAT-1];
  assign out_tag   = tag_p[LAT-1];

endmodule

// File: rtl/hq_mac_sched.sv
// Sequencer for the SOML H*X datapath: walks enabled code matrices, tracks
// cmult latency with a tag delay line and captures sums into a result buffer.
module hq_mac_sched
  import soml_pkg::*;
#(
  parameter int MULT_LAT = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [NUM_MAT-1:0]  mat_mask,
  output logic                busy,
  output logic                done,
  output logic                issue_valid,
  output logic [MAT_W-1:0]    mat_sel,
  output logic [ROW_W-1:0]    addr_rowH,
  output logic [COL_W-1:0]    addr_col,
  input  logic signed [W-1:0] sum_r,
  input  logic signed [W-1:0] sum_i,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic signed [W-1:0] rd_r,
  output logic signed [W-1:0] rd_i
);

  localparam int DW = $clog2(MULT_LAT + 1);

  state_t             state_q, state_d;
  logic [NUM_MAT-1:0] mask_q, mask_d;
  logic [MAT_W-1:0]   mat_q, mat_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [DW-1:0]      drain_q, drain_d;
  logic [MAT_W:0]     nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      mat_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      mat_q   <= mat_d;
      col_q   <= col_d;
      row_q   <= row_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    mat_d       = mat_q;
    col_d       = col_q;
    row_d       = row_q;
    drain_d     = drain_q;
    nxt         = '0;
    busy        = 1'b1;
    done        = 1'b0;
    issue_valid = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          mask_d = mat_mask;
          nxt    = next_mat(mat_mask, '0);
          if (nxt[MAT_W]) begin
            state_d = S_ISSUE;
            mat_d   = nxt[MAT_W-1:0];
            col_d   = '0;
            row_d   = '0;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_ISSUE: begin
        issue_valid = 1'b1;
        if (row_q == ROW_W'(NUM_ROW - 1)) begin
          row_d = '0;
          if (col_q == COL_W'(NUM_COL - 1)) begin
            col_d = '0;
            // Jump straight to the next enabled matrix so there is no bubble.
            nxt = next_mat(mask_q, {1'b0, mat_q} + (MAT_W + 1)'(1));
            if (nxt[MAT_W]) begin
              mat_d = nxt[MAT_W-1:0];
            end else begin
              state_d = S_DRAIN;
              drain_d = '0;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end else begin
          row_d = row_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (drain_q == DW'(MULT_LAT - 1)) state_d = S_DONE;
        else drain_d = drain_q + 1'b1;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mat_sel   = issue_valid ? mat_q : '0;
  assign addr_col  = issue_valid ? col_q : '0;
  assign addr_rowH = issue_valid ? row_q : '0;

  // ---- issue -> writeback: tag travels MULT_LAT stages with the multipliers
  logic              wr_vld;
  logic [ADDR_W-1:0] wr_addr;

  soml_tag_delay #(
    .LAT   (MULT_LAT),
    .TAG_W (ADDR_W)
  ) u_tag_delay (
    .clk       (clk),
    .clr       (rst),
    .in_valid  (issue_valid),
    .in_tag    (res_addr(mat_q, col_q, row_q)),
    .out_valid (wr_vld),
    .out_tag   (wr_addr)
  );

  logic [2*W-1:0] res_mem [NUM_ENT];

  // An abort discards whatever is at the tail this cycle as well.
  always_ff @(posedge clk) begin
    if (wr_vld && !rst) res_mem[wr_addr] <= {sum_r, sum_i};
  end

  // ---- read port: registered, old data on same-cycle collision
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_r <= '0;
      rd_i <= '0;
    end else begin
      {rd_r, rd_i} <= res_mem[rd_addr];
    end
  end

endmodule

// File: tb/tb_hq_mac_sched.sv
// Bench for hq_mac_sched: acts as the cmult/vadd datapath and checks issue
// order, timing and buffer contents against a matrix-level reference model.
module tb_hq_mac_sched;
  import soml_pkg::*;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  mat_mask = '0;
  logic        busy, done, issue_valid;
  logic [1:0]  mat_sel, addr_rowH;
  logic        addr_col;
  logic [15:0] sum_r = '0, sum_i = '0;
  logic [4:0]  rd_addr = '0;
  logic [15:0] rd_r, rd_i;

  hq_mac_sched #(.MULT_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .mat_mask(mat_mask),
    .busy(busy), .done(done), .issue_valid(issue_valid),
    .mat_sel(mat_sel), .addr_rowH(addr_rowH), .addr_col(addr_col),
    .sum_r(sum_r), .sum_i(sum_i), .rd_addr(rd_addr), .rd_r(rd_r), .rd_i(rd_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0;
  int bad = 0;

  // H rows (two lanes) and code-matrix columns, Q7.8 values
  int hr [4][2], hi [4][2];
  int xr [4][2][2], xi [4][2][2];
  bit ovr_en = 1'b0;

  logic [31:0] mdl [32];
  bit          known [32];

  function automatic logic [31:0] dp(input logic [4:0] a);
    int m, c, r, re, im;
    logic [31:0] rv, iv;
    m = int'(a[4:3]); c = int'(a[2]); r = int'(a[1:0]);
    re = 0; im = 0;
    for (int k = 0; k < 2; k++) begin
      re += (hr[r][k] * xr[m][c][k] - hi[r][k] * xi[m][c][k]) >>> FRAC;
      im += (hr[r][k] * xi[m][c][k] + hi[r][k] * xr[m][c][k]) >>> FRAC;
    end
    rv = re; iv = im;
    if (ovr_en && a == 5'b01011) rv = 32'h0000_00DB;
    return {rv[15:0], iv[15:0]};
  endfunction

  task automatic new_operands();
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 2; k++) begin
        hr[r][k] = int'($urandom_range(0, 1023)) - 512;
        hi[r][k] = int'($urandom_range(0, 1023)) - 512;
      end
    for (int m = 0; m < 4; m++)
      for (int c = 0; c < 2; c++)
        for (int k = 0; k < 2; k++) begin
          xr[m][c][k] = int'($urandom_range(0, 1023)) - 512;
          xi[m][c][k] = int'($urandom_range(0, 1023)) - 512;
        end
  endtask

  // Datapath emulation plus observation of scheduler outputs
  bit         hv0 = 0, hv1 = 0;
  logic [4:0] ha0 = '0, ha1 = '0;
  bit         mon_on = 0;
  int         c0 = 0;
  logic [4:0] iss_a [$];
  int         iss_c [$];
  int         done_c [$];
  int         busy_n = 0;

  always @(negedge clk) begin
    if (hv1) {sum_r, sum_i} = dp(ha1);
    else     {sum_r, sum_i} = $urandom;
    hv1 = hv0; ha1 = ha0;
    hv0 = issue_valid; ha0 = {mat_sel, addr_col, addr_rowH};
    if (mon_on) begin
      if (issue_valid) begin
        iss_a.push_back({mat_sel, addr_col, addr_rowH});
        iss_c.push_back(cyc - c0);
      end
      if (done) done_c.push_back(cyc - c0);
      if (busy) busy_n++;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check_buf(input string nm);
    for (int a = 0; a < 32; a++) begin
      if (known[a]) begin
        rd_addr = 5'(a);
        tick();
        total++;
        if ({rd_r, rd_i} !== mdl[a]) begin
          bad++;
          $display("FAIL %s buf[%0d]: got %h want %h", nm, a, {rd_r, rd_i}, mdl[a]);
        end
      end
    end
  endtask

  task automatic run_pass(input logic [3:0] mask, input bit repulse, input string nm);
    logic [4:0] exp_a [$];
    int exp_done, got_done, waited;
    for (int m = 0; m < 4; m++)
      if (mask[m])
        for (int c = 0; c < 2; c++)
          for (int r = 0; r < 4; r++) exp_a.push_back({2'(m), 1'(c), 2'(r)});
    exp_done = (exp_a.size() == 0) ? 1 : exp_a.size() + LAT + 1;
    iss_a.delete(); iss_c.delete(); done_c.delete(); busy_n = 0;
    new_operands();
    tick();
    mat_mask = mask; start = 1'b1; c0 = cyc; mon_on = 1'b1;
    tick();
    start = 1'b0; mat_mask = 4'($urandom);
    waited = 0;
    while (done_c.size() == 0 && waited < 200) begin
      start = (repulse && (waited == 3 || waited == 6));
      if (start) mat_mask = 4'hF;
      tick();
      waited++;
    end
    start = 1'b0;
    repeat (3) tick();
    mon_on = 1'b0;

    got_done = (done_c.size() == 1) ? done_c[0] : -done_c.size() - 1;
    total++;
    if (got_done != exp_done) begin
      bad++;
      $display("FAIL %s done_cycle: got %0d want %0d", nm, got_done, exp_done);
    end
    total++;
    if (iss_a.size() != exp_a.size()) begin
      bad++;
      $display("FAIL %s issue_count: got %0d want %0d", nm, iss_a.size(), exp_a.size());
    end else begin
      for (int i = 0; i < exp_a.size(); i++) begin
        total++;
        if (iss_a[i] !== exp_a[i] || iss_c[i] != i + 1) begin
          bad++;
          $display("FAIL %s issue[%0d]: got addr=%h cyc=%0d want addr=%h cyc=%0d",
                   nm, i, iss_a[i], iss_c[i], exp_a[i], i + 1);
        end
      end
    end
    total++;
    if (busy_n != exp_done) begin
      bad++;
      $display("FAIL %s busy_cycles: got %0d want %0d", nm, busy_n, exp_done);
    end
    foreach (exp_a[i]) begin
      mdl[exp_a[i]] = dp(exp_a[i]);
      known[exp_a[i]] = 1'b1;
    end
    check_buf(nm);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; mat_mask = 4'hF;
    repeat (3) tick();
    start = 1'b0;
    total++;
    if ({busy, done, issue_valid, mat_sel, addr_rowH, addr_col} !== '0) begin
      bad++;
      $display("FAIL reset_ctrl: got %b want 0", {busy, done, issue_valid, mat_sel, addr_rowH, addr_col});
    end
    total++;
    if ({rd_r, rd_i} !== 32'h0) begin
      bad++;
      $display("FAIL reset_rd: got %h want 0", {rd_r, rd_i});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_a2();
    ovr_en = 1'b1;
    run_pass(4'b0010, 1'b0, "single_a2");
    ovr_en = 1'b0;
    rd_addr = 5'b01011;
    tick();
    total++;
    if (rd_r !== 16'h00DB) begin
      bad++;
      $display("FAIL a2_row3_col0: got %h want 00db", rd_r);
    end
  endtask

  task automatic test_rst_mid();
    logic [4:0] a;
    new_operands();
    iss_a.delete(); iss_c.delete(); done_c.delete();
    tick();
    mat_mask = 4'b0010; start = 1'b1; c0 = cyc; mon_on = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if ({busy, done, issue_valid, mat_sel, addr_rowH, addr_col} !== '0) begin
      bad++;
      $display("FAIL rst_mid_ctrl: got %b want 0", {busy, done, issue_valid, mat_sel, addr_rowH, addr_col});
    end
    total++;
    if ({rd_r, rd_i} !== 32'h0) begin
      bad++;
      $display("FAIL rst_mid_rd: got %h want 0", {rd_r, rd_i});
    end
    repeat (12) tick();
    mon_on = 1'b0;
    total++;
    if (done_c.size() != 0) begin
      bad++;
      $display("FAIL rst_mid_done: got %0d pulses want 0", done_c.size());
    end
    // issues in cycles 1,2 landed before the abort; cycle 3's write coincides with it
    for (int r = 0; r < 2; r++) begin
      a = {2'd1, 1'b0, 2'(r)};
      mdl[a] = dp(a); known[a] = 1'b1;
    end
    known[5'b01010] = 1'b0;
    check_buf("rst_mid");
  endtask

  initial begin
    foreach (known[i]) known[i] = 1'b0;
    test_reset();
    test_single_a2();
    run_pass(4'hF, 1'b0, "full");
    run_pass(4'b1001, 1'b0, "sparse");
    run_pass(4'b0000, 1'b0, "mask_zero");
    run_pass(4'b0010, 1'b1, "restart_ignored");
    test_rst_mid();
    run_pass(4'b0010, 1'b0, "after_rst");
    run_pass(4'($urandom_range(1, 15)), 1'b0, "random_mask");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hq_mac_sched.md
Name: hq_mac_sched

Overview:
Sequencing controller for the SOML H·X complex dot-product datapath: two `cmult` lanes feeding a pair of `vadd` adders. On a start pulse it walks every enabled code matrix (A1, A2, B1, B2), column by column and H row by H row. It drives the LUT row/column addresses and tracks the multiplier pipeline latency with a valid/tag delay line. Each returned sum is stored in an internal result buffer, which the decoder metric stage reads back by address.

Parameters:
NUM_MAT, 4, code matrices sequenced (index 0=A1, 1=A2, 2=B1, 3=B2)
NUM_ROW, 4, H rows per column
NUM_COL, 2, columns per code matrix
MULT_LAT, 2, cycles from address issue to valid `sum_r`/`sum_i` (`cmult` register depth; `vadd` is combinational)
W, 16, complex component width, Q7.8 two's complement

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start  in  1  one-cycle request to run a full pass
mat_mask  in  NUM_MAT  enable per matrix, sampled on accepted start
busy  out  1  pass in progress
done  out  1  one-cycle pulse at pass completion
issue_valid  out  1  addresses below are valid this cycle
mat_sel  out  2  matrix LUT select
addr_rowH  out  2  H row address
addr_col  out  1  matrix column address
sum_r  in  W  real dot-product sum from datapath
sum_i  in  W  imag dot-product sum from datapath
rd_addr  in  5  result read address {mat,col,row}
rd_r  out  W  result real, registered, 1-cycle read latency
rd_i  out  W  result imag, registered, 1-cycle read latency

Behaviour:
- Reset values: `busy`, `done`, `issue_valid`, `mat_sel`, `addr_rowH`, `addr_col`, `rd_r`, `rd_i` = 0. Delay line cleared, FSM in IDLE. Buffer contents are not reset.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - `start`=1 latches `mat_mask`.
  - If mask ≠ 0: go to ISSUE with the counters at the first enabled matrix, col 0, row 0.
  - If mask = 0: go straight to DONE.
- `start` while not IDLE is ignored; no queueing.
- ISSUE:
  - `issue_valid`=1 every cycle, one address tuple per cycle.
  - Order: row fastest, then col, then matrix ascending. Disabled matrices are skipped with no bubble cycle.
  - After the last row/col of the last enabled matrix: go to DRAIN.
- Delay line: {valid, mat, col, row} shifted MULT_LAT stages. When the tail is valid, write `{sum_r, sum_i}` into buffer[{mat,col,row}] that cycle. A write therefore lands exactly MULT_LAT cycles after its issue.
- DRAIN: stays until the delay line is empty (MULT_LAT cycles), then goes to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- `busy`=1 in ISSUE, DRAIN and DONE.
- Read port:
  - Registered, available at all times.
  - A read and a write to the same address in the same cycle returns the old data.
  - Entries of skipped matrices keep their previous values.
- `rst` mid-pass: abort immediately. In-flight delay-line entries are discarded (no buffer write), FSM returns to IDLE, no `done` pulse.
- `start` coincident with `rst`: `rst` wins.
- Arithmetic: no saturation or rounding in this block. Sums are stored bit-exact as W-bit values.

Decomposition:
- Shared package `soml_pkg`:
  - matrix index constants MAT_A1..MAT_B2
  - NUM_ROW, NUM_COL
  - Q-format widths W=16, FRAC=8
  - result-address packing function {mat,col,row}
- One sub-module `soml_tag_delay`: parameterised MULT_LAT shift register carrying {valid, tag}, with synchronous clear.
- Result buffer: inline register array, 32 × 2W.

Test Plan:
- Single A2 pass, mask=4'b0010, start at cycle 0:
  - `issue_valid` in cycles 1–8, tuples (row,col) = (0,0),(1,0),(2,0),(3,0),(0,1)..(3,1), `mat_sel`=1
  - writes in cycles 3–10, `done` in cycle 11, `busy` high in cycles 1–11
  - drive `sum_r` = 0x00DB for row 3 col 0 → reading addr {1,0,3} gives `rd_r` = 0x00DB
- Full pass, mask=4'hF: 32 issues in consecutive cycles with no gaps; `done` 32+MULT_LAT+1 cycles after start; all 32 buffer entries match the bench model of H·X.
- Sparse mask=4'b1001: issues cover A1 then B2 back-to-back with no bubble; pre-loaded entries for A2/B1 are unchanged after the pass.
- mask=0: `done` pulses in the cycle after start, `busy` high only in that cycle, zero `issue_valid` cycles.
- `start` re-pulsed mid-pass: ignored, and the issue sequence is identical to the single-pass case.
- `rst` asserted in cycle 5 of an A2 pass: all outputs 0 the next cycle, no further buffer writes, no `done`; a fresh start afterwards completes normally.
